// File: rtl/subneg_data_mem_resp.sv
// subneg_data_mem_resp
// Responder end of the SUBNEG core's data-memory request/response interface.
// It services one read or write at a time against an internal word array and
// returns the result through a valid/ready response handshake.
// Optional feature macro: SUBNEG_DATA_MEM_WAIT_EN. When defined, WAIT_CYCLES
// wait states are inserted before every response. When undefined, there is a
// fixed one-cycle response latency and WAIT_CYCLES is ignored.

module subneg_data_mem_resp #(
    parameter int WIDTH       = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              rsp_err
);

    // Index width for the implemented words. The address range check is done
    // one bit wider, so DEPTH == 2**ADDR_W does not overflow.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

`ifdef SUBNEG_DATA_MEM_WAIT_EN
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic [WIDTH-1:0] mem [DEPTH];

    logic accept;
    logic req_in_range;
    logic lat_in_range;
    logic mem_wr;

    assign accept       = (state_q == IDLE) && req_valid && req_ready_q;
    assign req_in_range = {1'b0, req_addr} < DEPTH_W;
    assign lat_in_range = {1'b0, addr_q} < DEPTH_W;
    assign mem_wr       = accept && req_we && req_in_range;

    // Next-state and next-output logic. The response is registered during the
    // first RESP cycle. It then holds until the requester takes it.
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        we_d        = we_q;
        addr_d      = addr_q;
`ifdef SUBNEG_DATA_MEM_WAIT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d   = req_we;
                    addr_d = req_addr;
`ifdef SUBNEG_DATA_MEM_WAIT_EN
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = RESP;
                    end
`else
                    state_d = RESP;
`endif
                end
            end
            WAIT: begin
`ifdef SUBNEG_DATA_MEM_WAIT_EN
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`else
                state_d = RESP;
`endif
            end
            RESP: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !lat_in_range;
                    rsp_rdata_d = (lat_in_range && !we_q) ? mem[addr_q[IDX_W-1:0]] : '0;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_ready_d = (state_d == IDLE);
    end

    // Control and response registers. Reset drops any pending response at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
`ifdef SUBNEG_DATA_MEM_WAIT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
`ifdef SUBNEG_DATA_MEM_WAIT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Word array. A write commits at the accept edge. Reset does not clear it.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[req_addr[IDX_W-1:0]] <= req_wdata;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_subneg_data_mem_resp.sv
// Directed testbench for subneg_data_mem_resp, built with DEPTH=200 so the
// out-of-range path can be exercised.

module tb_subneg_data_mem_resp;

    localparam int WIDTH       = 8;
    localparam int ADDR_W      = 8;
    localparam int DEPTH       = 200;
    localparam int WAIT_CYCLES = 2;
`ifdef SUBNEG_DATA_MEM_WAIT_EN
    localparam int RSP_LAT = (WAIT_CYCLES > 0) ? 1 + WAIT_CYCLES : 1;
`else
    localparam int RSP_LAT = 1;
`endif

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [WIDTH-1:0]  req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_rdata;
    logic              rsp_err;

    int checks;
    int errors;

    subneg_data_mem_resp #(
        .WIDTH(WIDTH),
        .ADDR_W(ADDR_W),
        .DEPTH(DEPTH),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    // Free-running clock with rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Issues one request and waits for its response, up to a bounded number of cycles.
    // With busy set, it keeps driving a conflicting write while the transaction is in flight.
    task automatic applyStimulus(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                                 input bit busy);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) checkOutput("readyTimeout", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        if (busy) begin
            req_we    = 1'b1;
            req_addr  = 8'hC7;
            req_wdata = 8'hFF;
        end else begin
            req_valid = 1'b0;
            req_we    = 1'b0;
            req_addr  = 8'h00;
            req_wdata = 8'h00;
        end
        checkOutput("readyLowAfterAccept", 32'(req_ready), 32'd0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rsp_valid) checkOutput("rspTimeout", 32'(rsp_valid), 32'd1);
        checkOutput("latency", 32'(n), 32'(RSP_LAT));
        checkOutput("readyLowInResp", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
    endtask

    // Completes the response handshake and checks that the responder is idle again.
    task automatic finishResponse();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checkOutput("validLowAfterHs", 32'(rsp_valid), 32'd0);
        checkOutput("readyHighAfterHs", 32'(req_ready), 32'd1);
    endtask

    // Directed scenarios with hand-computed expected values.
    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        // Reset state
        #22;
        checkOutput("rstValid", 32'(rsp_valid), 32'd0);
        checkOutput("rstReady", 32'(req_ready), 32'd0);
        checkOutput("rstRdata", 32'(rsp_rdata), 32'd0);
        checkOutput("rstErr", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("readyLowBeforeEdge", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("readyAfterRelease", 32'(req_ready), 32'd1);

        // Write 0x10 <- 0xA5, then read it back
        applyStimulus(1'b1, 8'h10, 8'hA5, 1'b0);
        checkOutput("wrRdata", 32'(rsp_rdata), 32'h00);
        checkOutput("wrErr", 32'(rsp_err), 32'd0);
        finishResponse();

        // Read with the response stalled for five cycles
        applyStimulus(1'b0, 8'h10, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stallValid", 32'(rsp_valid), 32'd1);
            checkOutput("stallRdata", 32'(rsp_rdata), 32'hA5);
            checkOutput("stallErr", 32'(rsp_err), 32'd0);
            @(posedge clk);
            #1;
        end
        finishResponse();

        // Out-of-range handling with DEPTH=200
        applyStimulus(1'b1, 8'hC7, 8'h5A, 1'b0);
        checkOutput("wrC7Err", 32'(rsp_err), 32'd0);
        finishResponse();
        applyStimulus(1'b1, 8'hC8, 8'h3C, 1'b0);
        checkOutput("wrC8Err", 32'(rsp_err), 32'd1);
        checkOutput("wrC8Rdata", 32'(rsp_rdata), 32'h00);
        finishResponse();
        applyStimulus(1'b0, 8'hC8, 8'h00, 1'b0);
        checkOutput("rdC8Err", 32'(rsp_err), 32'd1);
        checkOutput("rdC8Rdata", 32'(rsp_rdata), 32'h00);
        finishResponse();
        applyStimulus(1'b0, 8'hC7, 8'h00, 1'b0);
        checkOutput("rdC7Rdata", 32'(rsp_rdata), 32'h5A);
        checkOutput("rdC7Err", 32'(rsp_err), 32'd0);
        finishResponse();

        // Requests driven while a transaction is in flight are ignored
        applyStimulus(1'b0, 8'h10, 8'h00, 1'b1);
        checkOutput("busyRdata", 32'(rsp_rdata), 32'hA5);
        finishResponse();
        applyStimulus(1'b0, 8'hC7, 8'h00, 1'b0);
        checkOutput("busyNoWrite", 32'(rsp_rdata), 32'h5A);
        finishResponse();

        // Asynchronous reset while a response is pending
        applyStimulus(1'b1, 8'h20, 8'h77, 1'b0);
        finishResponse();
        applyStimulus(1'b0, 8'h20, 8'h00, 1'b0);
        checkOutput("preRstRdata", 32'(rsp_rdata), 32'h77);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncRstValid", 32'(rsp_valid), 32'd0);
        checkOutput("asyncRstReady", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("readyLowPostRst", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("readyHighPostRst", 32'(req_ready), 32'd1);
        applyStimulus(1'b0, 8'h20, 8'h00, 1'b0);
        checkOutput("persistRdata", 32'(rsp_rdata), 32'h77);
        checkOutput("persistErr", 32'(rsp_err), 32'd0);
        finishResponse();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
